// File: rtl/shared_adder_sched.sv
// Round-robin scheduler sharing one external WIDTH-bit adder between two requesters.
// Optional saturation on carry-out is enabled by defining SHARED_ADD_SAT_EN.
module shared_adder_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_op_a,
    input  logic [WIDTH-1:0] a_op_b,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_op_a,
    input  logic [WIDTH-1:0] b_op_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic             res_id_q, res_id_d;
    logic             idle_ok;
    logic             grant_a;
    logic             grant_b;
    logic [WIDTH-1:0] issue_sum;

    // On a tie the requester that did not win last time is granted.
    assign idle_ok = ena & (state_q == IDLE);
    assign grant_a = idle_ok & a_valid & (~b_valid | last_q);
    assign grant_b = idle_ok & b_valid & (~a_valid | ~last_q);

`ifdef SHARED_ADD_SAT_EN
    assign issue_sum = add_cout ? {WIDTH{1'b1}} : add_sum;
`else
    assign issue_sum = add_sum;
`endif

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        res_sum_d  = res_sum_q;
        res_cout_d = res_cout_q;
        res_id_d   = res_id_q;
        unique case (state_q)
            IDLE: begin
                if (grant_a) begin
                    add_a_d  = a_op_a;
                    add_b_d  = a_op_b;
                    res_id_d = 1'b0;
                    last_d   = 1'b0;
                    state_d  = ISSUE;
                end else if (grant_b) begin
                    add_a_d  = b_op_a;
                    add_b_d  = b_op_b;
                    res_id_d = 1'b1;
                    last_d   = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                res_sum_d  = issue_sum;
                res_cout_d = add_cout;
                state_d    = RESP;
            end
            RESP: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            add_a_q    <= '0;
            add_b_q    <= '0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
            res_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
            res_id_q   <= res_id_d;
        end
    end

    // Readies are forced low while reset is asserted.
    assign a_ready   = grant_a & rst_n;
    assign b_ready   = grant_b & rst_n;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign res_valid = (state_q == RESP);
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_shared_adder_sched.sv
// Directed testbench for shared_adder_sched with a behavioural adder model.
// Covers arbitration, latency, overflow, backpressure, ena gating and async reset.
module tb_shared_adder_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         a_valid, b_valid;
    logic         a_ready, b_ready;
    logic [W-1:0] a_op_a, a_op_b, b_op_a, b_op_b;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cout;
    logic         res_valid, res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout, res_id;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] ovf_sum;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    shared_adder_sched #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_op_a    (a_op_a),
        .a_op_b    (a_op_b),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_op_a    (b_op_a),
        .b_op_b    (b_op_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef SHARED_ADD_SAT_EN
        ovf_sum = 8'hFF;
`else
        ovf_sum = 8'h01;
`endif
        rst_n = 1'b0; ena = 1'b1; res_ready = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        a_op_a = 8'h0F; a_op_b = 8'h01;
        b_op_a = 8'h20; b_op_b = 8'h22;
        #12;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_cout", res_cout, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        #1;

        // Both valid: A, B, A, B; one result every three cycles.
        for (int i = 0; i < 4; i++) begin
            chk("rr_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_b_ready", b_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            chk("rr_issue_valid", res_valid, 0);
            chk("rr_issue_ready", a_ready | b_ready, 0);
            tick();
            chk("rr_resp_valid", res_valid, 1);
            chk("rr_resp_id", res_id, i % 2);
            chk("rr_resp_sum", res_sum, (i % 2 == 0) ? 8'h10 : 8'h42);
            chk("rr_resp_cout", res_cout, 0);
            tick();
        end

        // A alone: 0F + 01.
        b_valid = 1'b0;
        #1;
        chk("a_only_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        chk("a_only_add_a", add_a, 8'h0F);
        chk("a_only_add_b", add_b, 8'h01);
        chk("a_only_issue_valid", res_valid, 0);
        tick();
        chk("a_only_valid", res_valid, 1);
        chk("a_only_sum", res_sum, 8'h10);
        chk("a_only_cout", res_cout, 0);
        chk("a_only_id", res_id, 0);
        tick();
        chk("a_only_idle", res_valid, 0);

        // Overflow FF + 02 held under backpressure for four cycles.
        res_ready = 1'b0;
        a_valid = 1'b1; a_op_a = 8'hFF; a_op_b = 8'h02;
        #1;
        chk("ovf_a_ready", a_ready, 1);
        tick();
        b_valid = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", res_valid, 1);
            chk("bp_sum", res_sum, ovf_sum);
            chk("bp_cout", res_cout, 1);
            chk("bp_id", res_id, 0);
            chk("bp_a_ready", a_ready, 0);
            chk("bp_b_ready", b_ready, 0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        chk("bp_release_idle", res_valid, 0);
        chk("bp_next_b_ready", b_ready, 1);
        chk("bp_next_a_ready", a_ready, 0);
        chk("idle_add_a_hold", add_a, 8'hFF);

        // B accepted, then ena drops during ISSUE; the result still arrives.
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        ena = 1'b0;
        tick();
        chk("ena_drop_valid", res_valid, 1);
        chk("ena_drop_sum", res_sum, 8'h42);
        chk("ena_drop_id", res_id, 1);
        tick();

        // ena low blocks a pending A request.
        a_valid = 1'b1; a_op_a = 8'h0F; a_op_b = 8'h01;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("ena0_a_ready", a_ready, 0);
            chk("ena0_res_valid", res_valid, 0);
            tick();
        end

        // Async reset during ISSUE, then A wins the first tie.
        ena = 1'b1;
        #1;
        chk("pre_rst_a_ready", a_ready, 1);
        tick();
        b_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_sum", res_sum, 0);
        chk("mid_rst_id", res_id, 0);
        chk("mid_rst_add_a", add_a, 0);
        chk("mid_rst_a_ready", a_ready, 0);
        chk("mid_rst_b_ready", b_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_a_ready", a_ready, 1);
        chk("post_rst_b_ready", b_ready, 0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        chk("post_rst_valid", res_valid, 1);
        chk("post_rst_sum", res_sum, 8'h10);
        chk("post_rst_id", res_id, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
